// File: rtl/master_mode_fsm.sv
// master_mode_fsm: top-level mode controller for the recorder/player.
// Edge-detects the key-state vector, sequences record / playback / pause /
// done, owns the record/playback time counter and keeps one recorded length
// per slot. All outputs except activeLength come straight from registers.
module master_mode_fsm #(
  parameter int NUM_KEYS    = 29,
  parameter int KEY_SPACE   = 28,
  parameter int KEY_RESTART = 18,
  parameter int KEY_PAUSE   = 24,
  parameter int KEY_LOOP    = 14,
  parameter int NUM_SLOTS   = 4,
  parameter int TIME_W      = 20
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_KEYS-1:0]          inputStateStorage,
  input  logic                         tick,
  output logic [2:0]                   currentState,
  output logic                         timerEnable,
  output logic [TIME_W-1:0]            timeCount,
  output logic [$clog2(NUM_SLOTS)-1:0] activeSlot,
  output logic [TIME_W-1:0]            activeLength,
  output logic [NUM_SLOTS-1:0]         slotValid,
  output logic                         loopMode
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_RECORD  = 3'd1,
    ST_PLAY    = 3'd2,
    ST_RESTART = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t               state_r, nextState_s;
  logic [NUM_KEYS-1:0]  keyPrev_r, keyEvent_s;
  logic [TIME_W-1:0]    timeCount_r, nextCount_s, lenData_s;
  logic [SLOT_W-1:0]    activeSlot_r, nextSlot_s, slotSel_s;
  logic [NUM_SLOTS-1:0] slotValid_r, nextValid_s;
  logic                 loopMode_r, nextLoop_s, timerEnable_r;
  logic                 lenWrite_s, slotHit_s, enterRecord_s;
  logic                 spaceEv_s, restartEv_s, pauseEv_s;
  logic                 unusedKeys_s;
  logic [TIME_W-1:0]    lengths_r [NUM_SLOTS];

  assign currentState = state_r;
  assign timerEnable  = timerEnable_r;
  assign timeCount    = timeCount_r;
  assign activeSlot   = activeSlot_r;
  assign slotValid    = slotValid_r;
  assign loopMode     = loopMode_r;
  assign activeLength = lengths_r[activeSlot_r];
  // Key events that no state decodes are folded into a single sink.
  assign unusedKeys_s = ^keyEvent_s;

  // Edge detection, slot-key decode and next-state / next-datapath logic.
  always_comb begin
    keyEvent_s    = inputStateStorage & ~keyPrev_r;
    spaceEv_s     = keyEvent_s[KEY_SPACE];
    restartEv_s   = keyEvent_s[KEY_RESTART];
    pauseEv_s     = keyEvent_s[KEY_PAUSE];
    slotHit_s     = 1'b0;
    slotSel_s     = {SLOT_W{1'b0}};
    nextState_s   = state_r;
    nextCount_s   = timeCount_r;
    nextSlot_s    = activeSlot_r;
    nextValid_s   = slotValid_r;
    nextLoop_s    = loopMode_r ^ keyEvent_s[KEY_LOOP];
    lenWrite_s    = 1'b0;
    lenData_s     = {TIME_W{1'b0}};
    enterRecord_s = 1'b0;

    // Scan downwards so the lowest pressed slot key ends up selected.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (keyEvent_s[i]) begin
        slotHit_s = 1'b1;
        slotSel_s = SLOT_W'(i);
      end else begin
        slotHit_s = slotHit_s;
      end
    end

    case (state_r)
      ST_START: begin
        if (spaceEv_s) begin
          enterRecord_s = 1'b1;
        end else if (slotHit_s) begin
          nextSlot_s = slotSel_s;
        end else begin
          nextState_s = ST_START;
        end
      end
      ST_RECORD: begin
        if (spaceEv_s) begin
          // Length excludes a tick arriving in the same cycle.
          lenWrite_s                = 1'b1;
          lenData_s                 = timeCount_r;
          nextValid_s[activeSlot_r] = 1'b1;
          nextCount_s               = {TIME_W{1'b0}};
          nextState_s               = ST_PLAY;
        end else if (tick && (&timeCount_r)) begin
          // Counter saturated: close the recording at full length.
          lenWrite_s                = 1'b1;
          lenData_s                 = {TIME_W{1'b1}};
          nextValid_s[activeSlot_r] = 1'b1;
          nextCount_s               = {TIME_W{1'b0}};
          nextState_s               = ST_PLAY;
        end else if (tick) begin
          nextCount_s = timeCount_r + {{(TIME_W-1){1'b0}}, 1'b1};
        end else begin
          nextCount_s = timeCount_r;
        end
      end
      ST_PLAY: begin
        if (spaceEv_s) begin
          enterRecord_s = 1'b1;
        end else if (restartEv_s) begin
          nextState_s = ST_RESTART;
        end else if (pauseEv_s) begin
          nextState_s = ST_PAUSE;
        end else if (timeCount_r == activeLength) begin
          nextState_s = loopMode_r ? ST_RESTART : ST_DONE;
        end else if (tick) begin
          nextCount_s = timeCount_r + {{(TIME_W-1){1'b0}}, 1'b1};
        end else begin
          nextCount_s = timeCount_r;
        end
      end
      ST_RESTART: begin
        // Single cycle; key events other than Tab are ignored here.
        nextCount_s = {TIME_W{1'b0}};
        nextState_s = ST_PLAY;
      end
      ST_PAUSE: begin
        if (spaceEv_s) begin
          enterRecord_s = 1'b1;
        end else if (restartEv_s) begin
          nextState_s = ST_RESTART;
        end else if (pauseEv_s) begin
          nextState_s = ST_PLAY;
        end else begin
          nextState_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (spaceEv_s) begin
          enterRecord_s = 1'b1;
        end else if (restartEv_s) begin
          nextState_s = slotValid_r[activeSlot_r] ? ST_RESTART : ST_DONE;
        end else if (slotHit_s) begin
          // Counter keeps showing the length of whichever slot is active.
          nextSlot_s  = slotSel_s;
          nextCount_s = lengths_r[slotSel_s];
        end else begin
          nextState_s = ST_DONE;
        end
      end
      default: begin
        nextState_s = ST_START;
        nextCount_s = {TIME_W{1'b0}};
      end
    endcase

    // Common RECORD entry: restart the counter and invalidate the slot.
    if (enterRecord_s) begin
      nextState_s               = ST_RECORD;
      nextCount_s               = {TIME_W{1'b0}};
      nextValid_s[activeSlot_r] = 1'b0;
    end else begin
      nextValid_s = nextValid_s;
    end
  end

  // State, counter, slot bookkeeping, length store and key history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= ST_START;
      keyPrev_r     <= {NUM_KEYS{1'b1}};
      timeCount_r   <= {TIME_W{1'b0}};
      activeSlot_r  <= {SLOT_W{1'b0}};
      slotValid_r   <= {NUM_SLOTS{1'b0}};
      loopMode_r    <= 1'b0;
      timerEnable_r <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        lengths_r[i] <= {TIME_W{1'b0}};
      end
    end else begin
      state_r       <= nextState_s;
      keyPrev_r     <= inputStateStorage;
      timeCount_r   <= nextCount_s;
      activeSlot_r  <= nextSlot_s;
      slotValid_r   <= nextValid_s;
      loopMode_r    <= nextLoop_s;
      timerEnable_r <= (nextState_s == ST_RECORD) || (nextState_s == ST_PLAY);
      if (lenWrite_s) begin
        lengths_r[activeSlot_r] <= lenData_s;
      end
    end
  end
endmodule

// File: tb/tb_master_mode_fsm.sv
// tb_master_mode_fsm: directed stimulus with a queue-based scoreboard.
// The stimulus pushes expected register values due after a given clock edge;
// a separate monitor pops and compares them on the falling edge.
module tb_master_mode_fsm;
  logic        clk = 1'b0;
  logic        resetn;
  logic [28:0] keys;
  logic        tick;

  logic [2:0]  st,   stS;
  logic        ten,  tenS;
  logic [19:0] tc,   len;
  logic [3:0]  tcS,  lenS;
  logic [1:0]  slot, slotS;
  logic [3:0]  vld,  vldS;
  logic        lp,   lpS;

  localparam logic [28:0] KSP  = 29'd1 << 28;
  localparam logic [28:0] KR   = 29'd1 << 18;
  localparam logic [28:0] KP   = 29'd1 << 24;
  localparam logic [28:0] KTAB = 29'd1 << 14;
  localparam logic [28:0] K1   = 29'd1 << 1;
  localparam logic [28:0] K2   = 29'd1 << 2;
  localparam logic [28:0] KNO  = 29'd0;

  always #5 clk = ~clk;

  master_mode_fsm dut (
    .clk(clk), .resetn(resetn), .inputStateStorage(keys), .tick(tick),
    .currentState(st), .timerEnable(ten), .timeCount(tc), .activeSlot(slot),
    .activeLength(len), .slotValid(vld), .loopMode(lp)
  );

  master_mode_fsm #(.TIME_W(4)) dutS (
    .clk(clk), .resetn(resetn), .inputStateStorage(keys), .tick(tick),
    .currentState(stS), .timerEnable(tenS), .timeCount(tcS), .activeSlot(slotS),
    .activeLength(lenS), .slotValid(vldS), .loopMode(lpS)
  );

  typedef struct {
    int    due;
    string nm;
    bit    sel;
    int    st;
    int    tc;   // -1 = not compared
    int    len;
    int    vld;
    int    slot;
    int    lp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compare every expectation due at the edge just passed.
  always @(negedge clk) begin
    exp_t e;
    int   ast, atc, alen, avld, aslot, alp, aten, eten;
    bit   bad;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.sel) begin
        ast = stS; atc = tcS; alen = lenS; avld = vldS; aslot = slotS; alp = lpS; aten = tenS;
      end else begin
        ast = st; atc = tc; alen = len; avld = vld; aslot = slot; alp = lp; aten = ten;
      end
      eten = (e.st == 1 || e.st == 2) ? 1 : 0;
      bad = (e.due != cyc) || (ast != e.st) || (e.tc >= 0 && atc != e.tc) ||
            (alen != e.len) || (avld != e.vld) || (aslot != e.slot) ||
            (alp != e.lp) || (aten != eten);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got st=%0d tc=%0d len=%0d vld=%0d slot=%0d lp=%0d ten=%0d want st=%0d tc=%0d len=%0d vld=%0d slot=%0d lp=%0d ten=%0d",
                 e.nm, cyc, e.due, ast, atc, alen, avld, aslot, alp, aten,
                 e.st, e.tc, e.len, e.vld, e.slot, e.lp, eten);
      end
    end
  end

  task automatic expectNext(input string nm, input bit sel, input int est, input int etc,
                            input int elen, input int evld, input int eslot, input int elp);
    exp_t e;
    e.due = cyc + 1; e.nm = nm; e.sel = sel; e.st = est; e.tc = etc;
    e.len = elen; e.vld = evld; e.slot = eslot; e.lp = elp;
    q.push_back(e);
  endtask

  task automatic step(input logic [28:0] k, input logic t);
    keys = k;
    tick = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d queued=%0d", cyc, q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; keys = KNO; tick = 1'b0;
    @(negedge clk);

    // Reset values and basic record / playback / done
    expectNext("reset", 0, 0, 0, 0, 0, 0, 0);
    expectNext("resetS", 1, 0, 0, 0, 0, 0, 0);
    step(KNO, 0); step(KNO, 0);
    resetn = 1'b1; step(KNO, 0);
    expectNext("rec_entry", 0, 1, 0, 0, 0, 0, 0); step(KSP, 0);
    repeat (4) step(KNO, 1);
    expectNext("rec_5ticks", 0, 1, 5, 0, 0, 0, 0); step(KNO, 1);
    expectNext("rec_stop", 0, 2, 0, 5, 1, 0, 0); step(KSP, 0);
    repeat (4) step(KNO, 1);
    expectNext("play_5", 0, 2, 5, 5, 1, 0, 0); step(KNO, 1);
    expectNext("done", 0, 5, 5, 5, 1, 0, 0); step(KNO, 0);

    // Space held through reset, then held for 100 cycles
    resetn = 1'b0;
    expectNext("rst2", 0, 0, 0, 0, 0, 0, 0);
    step(KSP, 0); step(KSP, 0);
    resetn = 1'b1;
    step(KSP, 0); step(KSP, 0);
    expectNext("held_rst", 0, 0, 0, 0, 0, 0, 0); step(KSP, 0);
    step(KNO, 0);
    expectNext("hold_first", 0, 1, 0, 0, 0, 0, 0); step(KSP, 0);
    repeat (98) step(KSP, 0);
    expectNext("hold_100", 0, 1, 0, 0, 0, 0, 0); step(KSP, 0);
    // Press-release-press gives two events; zero length ends at once
    step(KNO, 0);
    expectNext("pr_1", 0, 2, 0, 0, 1, 0, 0); step(KSP, 0);
    expectNext("zero_len_done", 0, 5, 0, 0, 1, 0, 0); step(KNO, 0);
    expectNext("pr_2", 0, 1, 0, 0, 0, 0, 0); step(KSP, 0);

    // Loop playback of a length-3 recording in slot 2
    resetn = 1'b0; step(KNO, 0);
    resetn = 1'b1; step(KNO, 0);
    expectNext("tab_on", 0, 0, 0, 0, 0, 0, 1); step(KTAB, 0);
    expectNext("sel2", 0, 0, 0, 0, 0, 2, 1); step(K2, 0);
    expectNext("rec2", 0, 1, 0, 0, 0, 2, 1); step(KSP, 0);
    repeat (3) step(KNO, 1);
    expectNext("stop2", 0, 2, 0, 3, 4, 2, 1); step(KSP, 0);
    repeat (2) step(KNO, 1);
    expectNext("loop_at3", 0, 2, 3, 3, 4, 2, 1); step(KNO, 1);
    expectNext("loop_rst", 0, 3, 3, 3, 4, 2, 1); step(KNO, 1);
    expectNext("loop_tc0", 0, 2, 0, 3, 4, 2, 1); step(KNO, 1);
    repeat (3) step(KNO, 1);
    expectNext("loop_rst2", 0, 3, 3, 3, 4, 2, 1); step(KNO, 0);
    expectNext("loop_tc0_2", 0, 2, 0, 3, 4, 2, 1); step(KNO, 0);

    // Pause / resume / restart
    step(KNO, 1);
    expectNext("pb_2", 0, 2, 2, 3, 4, 2, 1); step(KNO, 1);
    expectNext("pause", 0, 4, 2, 3, 4, 2, 1); step(KP, 0);
    repeat (3) step(KNO, 1);
    expectNext("pause_hold", 0, 4, 2, 3, 4, 2, 1); step(KNO, 1);
    expectNext("resume", 0, 2, 2, 3, 4, 2, 1); step(KP, 0);
    expectNext("restart", 0, 3, 2, 3, 4, 2, 1); step(KR, 0);
    expectNext("restart_tc0", 0, 2, 0, 3, 4, 2, 1); step(KNO, 0);

    // Same-cycle priorities, loop off, DONE handling
    expectNext("sp_r", 0, 1, 0, 3, 0, 2, 1); step(KSP | KR, 0);
    step(KNO, 1); step(KNO, 1);
    expectNext("sp_tick", 0, 2, 0, 2, 4, 2, 1); step(KSP, 1);
    expectNext("tab_off", 0, 2, 0, 2, 4, 2, 0); step(KTAB, 0);
    step(KNO, 1); step(KNO, 1);
    expectNext("done2", 0, 5, 2, 2, 4, 2, 0); step(KNO, 0);
    expectNext("done_r", 0, 3, 2, 2, 4, 2, 0); step(KR, 0);
    expectNext("done_r_pb", 0, 2, 0, 2, 4, 2, 0); step(KNO, 0);
    step(KNO, 1); step(KNO, 1); step(KNO, 0);
    expectNext("done_sel1", 0, 5, -1, 0, 4, 1, 0); step(K1, 0);
    expectNext("done_r_inval", 0, 5, -1, 0, 4, 1, 0); step(KR, 0);

    // Counter saturation on the 4-bit instance
    resetn = 1'b0;
    expectNext("rstS2", 1, 0, 0, 0, 0, 0, 0); step(KNO, 0);
    resetn = 1'b1; step(KNO, 0);
    expectNext("recS", 1, 1, 0, 0, 0, 0, 0); step(KSP, 0);
    repeat (14) step(KNO, 1);
    expectNext("s15", 1, 1, 15, 0, 0, 0, 0); step(KNO, 1);
    expectNext("satS", 1, 2, 0, 15, 1, 0, 0);
    expectNext("main16", 0, 1, 16, 0, 0, 0, 0); step(KNO, 1);
    expectNext("satS_pb", 1, 2, 1, 15, 1, 0, 0); step(KNO, 1);

    step(KNO, 0); step(KNO, 0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
